// File: rtl/apb_intercon_mm_pkg.sv
// apb_intercon_mm_pkg: shared FSM encoding and width helpers for the APB interconnect (package apb_ic_pkg).
package apb_ic_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  function automatic int field_width(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction
  function automatic int idx_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/apb_intercon_mm_arbiter.sv
// apb_rr_arbiter: round-robin grant; winner is the first requester strictly after last_grant.
module apb_rr_arbiter
  import apb_ic_pkg::*;
#(
  parameter int N_MASTERS = 4,
  localparam int GW = idx_width(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] reqs,
  input  logic                 advance,
  output logic [GW-1:0]        grant,
  output logic                 valid
);
  logic [GW-1:0] last_grant;
  assign valid = |reqs;
  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      if (reqs[GW'((int'(last_grant) + i) % N_MASTERS)]) grant = GW'((int'(last_grant) + i) % N_MASTERS);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant <= GW'(N_MASTERS - 1);
    else if (advance) last_grant <= grant;
  end
endmodule

// File: rtl/apb_intercon_mm.sv
// apb_intercon_mm: round-robin multi-master APB interconnect with address-field slave decode.
// Optional APB_IC_TIMEOUT_EN: ACCESS aborts with PSLVERR after TIMEOUT_CYCLES without PREADY.
module apb_intercon_mm
  import apb_ic_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int N_SLAVES       = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_MSB       = 7,
  parameter int ADDR_LSB       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  S_PADDR,
  input  logic [N_MASTERS-1:0]             S_PWRITE,
  input  logic [N_MASTERS-1:0]             S_PSELx,
  input  logic [N_MASTERS-1:0]             S_PENABLE,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  S_PWDATA,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  S_PRDATA,
  output logic [N_MASTERS-1:0]             S_PREADY,
  output logic [N_MASTERS-1:0]             S_PSLVERR,
  output logic [ADDR_WIDTH-1:0]            M_PADDR,
  output logic                             M_PWRITE,
  output logic [N_SLAVES-1:0]              M_PSELx,
  output logic                             M_PENABLE,
  output logic [DATA_WIDTH-1:0]            M_PWDATA,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]   M_PRDATA,
  input  logic [N_SLAVES-1:0]              M_PREADY,
  input  logic [N_SLAVES-1:0]              M_PSLVERR
);
  localparam int GW = idx_width(N_MASTERS);
  localparam int FW = field_width(ADDR_MSB, ADDR_LSB);
  state_t state, state_d;
  logic [GW-1:0] grant, gnt_q;
  logic valid, advance, mapped, sel_rdy, sel_err, tmo, done, err;
  logic [FW-1:0] field;
  logic [N_SLAVES-1:0] dec;
  logic [DATA_WIDTH-1:0] sel_data, rdata;
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;
  apb_rr_arbiter #(.N_MASTERS(N_MASTERS)) u_arb (
    .clk(clk), .reset(reset), .reqs(S_PSELx), .advance(advance), .grant(grant), .valid(valid)
  );
  assign advance  = (state == IDLE) && valid;
  assign M_PADDR  = S_PADDR[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign M_PWDATA = S_PWDATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign M_PWRITE = S_PWRITE[gnt_q];
  assign field    = M_PADDR[ADDR_MSB:ADDR_LSB];
  // Loop decode keeps out-of-range fields from ever indexing past the slave vectors.
  always_comb begin
    dec = '0;
    sel_rdy = 1'b0;
    sel_err = 1'b0;
    sel_data = '0;
    for (int s = 0; s < N_SLAVES; s++) begin
      if (int'(field) == s) begin
        dec[s] = 1'b1;
        sel_rdy = M_PREADY[s];
        sel_err = M_PSLVERR[s];
        sel_data = M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  assign mapped    = |dec;
  assign M_PSELx   = (state != IDLE) ? dec : '0;
  assign M_PENABLE = (state == ACCESS);
`ifdef APB_IC_TIMEOUT_EN
  localparam int TW = idx_width(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else tmo_cnt <= (state == ACCESS && !done) ? tmo_cnt + TW'(1) : '0;
  end
  assign tmo = (state == ACCESS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  assign done      = (state == ACCESS) && (!mapped || sel_rdy || tmo);
  assign err       = !mapped || !sel_rdy || sel_err;
  assign rdata     = (mapped && sel_rdy) ? sel_data : '0;
  assign S_PREADY  = done ? (N_MASTERS'(1) << gnt_q) : '0;
  assign S_PSLVERR = (done && err) ? (N_MASTERS'(1) << gnt_q) : '0;
  always_comb begin
    S_PRDATA = '0;
    if (done) S_PRDATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end
  always_comb begin
    state_d = (state == IDLE) ? (valid ? SETUP : IDLE) : (state == SETUP) ? ACCESS : (done ? IDLE : ACCESS);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt_q <= '0;
    end else begin
      state <= state_d;
      if (advance) gnt_q <= grant;
    end
  end
endmodule

// File: tb/tb_apb_intercon_mm.sv
// tb_apb_intercon_mm: directed self-checking bench for apb_intercon_mm (4 masters, 8 slaves).
module tb_apb_intercon_mm;
  localparam int NM = 4, NS = 8, AW = 16, DW = 16;
  logic clk, reset;
  logic [NM*AW-1:0] S_PADDR;
  logic [NM-1:0] S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, S_PSLVERR;
  logic [NM*DW-1:0] S_PWDATA, S_PRDATA;
  logic [AW-1:0] M_PADDR;
  logic M_PWRITE, M_PENABLE;
  logic [NS-1:0] M_PSELx, M_PREADY, M_PSLVERR;
  logic [DW-1:0] M_PWDATA;
  logic [NS*DW-1:0] M_PRDATA;
  logic [DW-1:0] sdata [NS];
  int swait [NS];
  logic [NS-1:0] serr;
  int acc, p0;
  logic [DW-1:0] wcap;
  int checks, errors;

  apb_intercon_mm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .ADDR_MSB(7), .ADDR_LSB(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .S_PSLVERR(S_PSLVERR), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .M_PSLVERR(M_PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: each slave is ready once the access has lasted swait extra cycles.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      M_PREADY[s] = (acc >= swait[s]);
      M_PRDATA[s*DW +: DW] = sdata[s];
    end
    M_PSLVERR = serr;
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) acc <= 0;
    else acc <= (M_PENABLE && !(|S_PREADY)) ? acc + 1 : 0;
  end
  always @(posedge clk) begin
    if (M_PENABLE && |(M_PSELx & M_PREADY) && M_PWRITE) wcap <= M_PWDATA;
    if (S_PREADY[0]) p0 <= p0 + 1;
  end

  function automatic int oh2idx(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_done(input int max, output bit ok, output int idx, output int cyc);
    ok = 0; idx = -1; cyc = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      cyc++;
      if (|S_PREADY) begin
        ok = 1;
        idx = oh2idx(S_PREADY);
        return;
      end
    end
  endtask

  task automatic set_master(input int m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    S_PADDR[m*AW +: AW] = a;
    S_PWRITE[m] = w;
    S_PWDATA[m*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (M_PSELx !== 8'h00) begin errors++; $display("FAIL reset_psel got %h exp 00", M_PSELx); end
    checks++; if (M_PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable got %b exp 0", M_PENABLE); end
    checks++; if (S_PREADY !== 4'h0) begin errors++; $display("FAIL reset_pready got %h exp 0", S_PREADY); end
    checks++; if (S_PSLVERR !== 4'h0) begin errors++; $display("FAIL reset_pslverr got %h exp 0", S_PSLVERR); end
    checks++; if (S_PRDATA !== '0) begin errors++; $display("FAIL reset_prdata got %h exp 0", S_PRDATA); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int start;
    start = p0;
    set_master(0, 16'h0030, 1'b1, 16'hBEEF);
    S_PSELx = 4'b0001;
    @(negedge clk);
    checks++; if (M_PSELx !== 8'h08) begin errors++; $display("FAIL single_setup_psel got %h exp 08", M_PSELx); end
    checks++; if (M_PENABLE !== 1'b0 || S_PREADY !== 4'h0) begin errors++; $display("FAIL single_setup_en got %b/%h exp 0/0", M_PENABLE, S_PREADY); end
    @(negedge clk);
    checks++; if (M_PENABLE !== 1'b1 || M_PSELx !== 8'h08) begin errors++; $display("FAIL single_access got %b/%h exp 1/08", M_PENABLE, M_PSELx); end
    checks++; if (S_PREADY !== 4'b0001) begin errors++; $display("FAIL single_pready got %h exp 1", S_PREADY); end
    checks++; if (M_PWDATA !== 16'hBEEF || M_PADDR !== 16'h0030 || M_PWRITE !== 1'b1) begin errors++; $display("FAIL single_bus got %h/%h/%b exp beef/0030/1", M_PWDATA, M_PADDR, M_PWRITE); end
    S_PSELx = 4'b0000;
    @(negedge clk);
    checks++; if (M_PSELx !== 8'h00 || M_PENABLE !== 1'b0) begin errors++; $display("FAIL single_idle got %h/%b exp 00/0", M_PSELx, M_PENABLE); end
    checks++; if (wcap !== 16'hBEEF) begin errors++; $display("FAIL single_wdata got %h exp beef", wcap); end
    repeat (2) @(negedge clk);
    checks++; if (p0 - start !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", p0 - start); end
  endtask

  task automatic test_round_robin();
    bit ok; int idx, cyc;
    apply_reset();
    for (int m = 0; m < NM; m++) set_master(m, AW'(m << 4), 1'b0, '0);
    S_PSELx = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, ok, idx, cyc);
      checks++; if (!ok || idx !== k % 4) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", k, idx, k % 4); end
      checks++; if (cyc !== (k == 0 ? 2 : 3)) begin errors++; $display("FAIL rr_spacing%0d got %0d exp %0d", k, cyc, k == 0 ? 2 : 3); end
    end
    S_PSELx = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_states();
    int nacc;
    bit seen;
    nacc = 0; seen = 0;
    swait[5] = 3;
    sdata[5] = 16'h1234;
    set_master(1, 16'h0050, 1'b0, '0);
    S_PSELx = 4'b0010;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (M_PENABLE) nacc++;
      if (|S_PREADY) begin
        seen = 1;
        checks++; if (S_PRDATA !== 64'h0000_0000_1234_0000) begin errors++; $display("FAIL wait_prdata got %h exp 0000000012340000", S_PRDATA); end
        checks++; if (S_PREADY !== 4'b0010 || S_PSLVERR !== 4'h0) begin errors++; $display("FAIL wait_resp got %h/%h exp 2/0", S_PREADY, S_PSLVERR); end
        S_PSELx = 4'b0000;
      end
    end
    checks++; if (nacc !== 4) begin errors++; $display("FAIL wait_access_len got %0d exp 4", nacc); end
    swait[5] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unmapped();
    set_master(2, 16'h0090, 1'b0, '0);
    S_PSELx = 4'b0100;
    @(negedge clk);
    checks++; if (M_PSELx !== 8'h00 || M_PENABLE !== 1'b0) begin errors++; $display("FAIL unmap_setup got %h/%b exp 00/0", M_PSELx, M_PENABLE); end
    @(negedge clk);
    checks++; if (M_PSELx !== 8'h00 || M_PENABLE !== 1'b1) begin errors++; $display("FAIL unmap_access got %h/%b exp 00/1", M_PSELx, M_PENABLE); end
    checks++; if (S_PREADY !== 4'b0100 || S_PSLVERR !== 4'b0100) begin errors++; $display("FAIL unmap_resp got %h/%h exp 4/4", S_PREADY, S_PSLVERR); end
    checks++; if (S_PRDATA !== '0) begin errors++; $display("FAIL unmap_prdata got %h exp 0", S_PRDATA); end
    S_PSELx = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_slave_err();
    bit ok; int idx, cyc;
    serr[2] = 1'b1;
    sdata[2] = 16'h5A5A;
    set_master(3, 16'h0020, 1'b0, '0);
    S_PSELx = 4'b1000;
    wait_done(10, ok, idx, cyc);
    checks++; if (!ok || idx !== 3 || S_PSLVERR !== 4'b1000) begin errors++; $display("FAIL slverr_resp got %0d/%h exp 3/8", idx, S_PSLVERR); end
    checks++; if (S_PRDATA !== 64'h5A5A_0000_0000_0000) begin errors++; $display("FAIL slverr_prdata got %h exp 5a5a000000000000", S_PRDATA); end
    S_PSELx = 4'b0000;
    serr[2] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef APB_IC_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen; int idx, cyc, nacc;
    nacc = 0; seen = 0;
    swait[7] = 1000;
    set_master(0, 16'h0070, 1'b0, '0);
    set_master(1, 16'h0000, 1'b0, '0);
    S_PSELx = 4'b0011;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (M_PENABLE) nacc++;
      if (|S_PREADY) begin
        seen = 1;
        checks++; if (S_PREADY !== 4'b0001 || S_PSLVERR !== 4'b0001 || S_PRDATA !== '0) begin errors++; $display("FAIL tmo_resp got %h/%h/%h exp 1/1/0", S_PREADY, S_PSLVERR, S_PRDATA); end
        S_PSELx = 4'b0010;
      end
    end
    checks++; if (nacc !== 8) begin errors++; $display("FAIL tmo_cycles got %0d exp 8", nacc); end
    wait_done(10, ok, idx, cyc);
    checks++; if (!ok || idx !== 1 || S_PSLVERR !== 4'h0) begin errors++; $display("FAIL tmo_next got %0d/%h exp 1/0", idx, S_PSLVERR); end
    S_PSELx = 4'b0000;
    swait[7] = 0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    bit ok; int idx, cyc;
    swait[5] = 3;
    set_master(1, 16'h0050, 1'b0, '0);
    S_PSELx = 4'b0010;
    repeat (2) @(negedge clk);
    checks++; if (M_PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got %b exp 1", M_PENABLE); end
    #2 reset = 1'b0;
    #1;
    checks++; if (M_PSELx !== 8'h00 || M_PENABLE !== 1'b0 || S_PREADY !== 4'h0) begin errors++; $display("FAIL rstmid_clear got %h/%b/%h exp 00/0/0", M_PSELx, M_PENABLE, S_PREADY); end
    S_PSELx = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    swait[5] = 0;
    set_master(0, 16'h0000, 1'b0, '0);
    set_master(2, 16'h0010, 1'b0, '0);
    S_PSELx = 4'b0101;
    wait_done(10, ok, idx, cyc);
    checks++; if (!ok || idx !== 0) begin errors++; $display("FAIL rstmid_first_grant got %0d exp 0", idx); end
    S_PSELx = 4'b0100;
    wait_done(10, ok, idx, cyc);
    checks++; if (!ok || idx !== 2) begin errors++; $display("FAIL rstmid_second_grant got %0d exp 2", idx); end
    S_PSELx = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; p0 = 0; wcap = '0;
    reset = 1'b0;
    S_PADDR = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0; S_PWDATA = '0;
    serr = '0;
    for (int s = 0; s < NS; s++) begin
      sdata[s] = DW'(16'hA000 + s);
      swait[s] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wait_states();
    test_unmapped();
    test_slave_err();
`ifdef APB_IC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
